// File: rtl/ift_stim_sequencer.sv
// Record-table stimulus sequencer for IFT benches: plays stored data/taint records in order,
// each for max(hold,1) cycles, once or looping.
module ift_stim_sequencer #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DW    = 1,
    parameter int unsigned TW    = 32,
    parameter int unsigned CW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned RW    = NCH * (TW + DW) + CW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [RW-1:0]     wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [AW-1:0]     last_idx,
    output logic [NCH*DW-1:0] data_out,
    output logic [NCH*TW-1:0] taint_out,
    output logic [AW-1:0]     rec_idx,
    output logic              rec_strobe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [NCH*DW-1:0]   data_q, data_d;
    logic [NCH*TW-1:0]   taint_q, taint_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic                loop_q, loop_d;
    logic [AW-1:0]       last_q, last_d;

    logic [RW-1:0]       mem [DEPTH];
    logic                load;
    logic [AW-1:0]       load_addr;
    logic [RW-1:0]       rec;
    logic [CW-1:0]       rec_hold;
    logic [AW-1:0]       last_clamped;

    // Only a non-power-of-two table can be addressed past its end.
    if (2 ** AW == DEPTH) begin : g_pow2
        assign last_clamped = last_idx;
    end else begin : g_clamp
        localparam logic [AW-1:0] MaxIdx = AW'(DEPTH - 1);
        assign last_clamped = (last_idx > MaxIdx) ? MaxIdx : last_idx;
    end

    // Sequencing: decides when and which slot to load.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        loop_d    = loop_q;
        last_d    = last_q;
        load      = 1'b0;
        load_addr = '0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StPlay;
                    done_d  = 1'b0;
                    loop_d  = loop_mode;
                    last_d  = last_clamped;
                    load    = 1'b1;
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if (idx_q < last_q) begin
                        load      = 1'b1;
                        load_addr = idx_q + AW'(1);
                    end else if (loop_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Combinational read; the write lands on the edge, so a same-edge load sees old contents.
    assign rec      = mem[load_addr];
    assign rec_hold = rec[CW-1:0];

    always_comb begin
        idx_d    = idx_q;
        data_d   = data_q;
        taint_d  = taint_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (load) begin
            idx_d    = load_addr;
            data_d   = rec[CW +: NCH*DW];
            taint_d  = rec[CW + NCH*DW +: NCH*TW];
            cnt_d    = (rec_hold == '0) ? '0 : rec_hold - CW'(1);
            strobe_d = 1'b1;
        end else if (state_q == StPlay && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            taint_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            loop_q   <= 1'b0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            taint_q  <= taint_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            loop_q   <= loop_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign data_out   = data_q;
    assign taint_out  = taint_q;
    assign rec_idx    = idx_q;
    assign rec_strobe = strobe_q;
    assign busy       = (state_q == StPlay);
    assign done       = done_q;

endmodule
